// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing one single-port data RAM between CPU and DMA.
// Optional ARB_LOCK_EN adds CPU_LOCK for atomic CPU read-modify-write.
module ram_arbiter #(
  parameter int ADDR_W    = 7,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              CPU_REQ,
  input  logic              CPU_WE,
  input  logic [ADDR_W-1:0] CPU_ADDR,
  input  logic [DATA_W-1:0] CPU_WDATA,
`ifdef ARB_LOCK_EN
  input  logic              CPU_LOCK,
`endif
  output logic              CPU_GNT,
  output logic              CPU_RVALID,
  input  logic              DMA_REQ,
  input  logic              DMA_WE,
  input  logic [ADDR_W-1:0] DMA_ADDR,
  input  logic [DATA_W-1:0] DMA_WDATA,
  input  logic              DMA_LAST,
  output logic              DMA_GNT,
  output logic              DMA_RVALID,
  output logic [DATA_W-1:0] RDATA,
  output logic              RAM_CS,
  output logic              RAM_WE,
  output logic              RAM_OE,
  output logic [ADDR_W-1:0] RAM_ADDR,
  output logic [DATA_W-1:0] RAM_WDATA,
  input  logic [DATA_W-1:0] RAM_RDATA
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CPU  = 2'd1;
  localparam logic [1:0] S_DMA  = 2'd2;

  localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST - 1);

  logic [1:0]       state;
  logic [1:0]       state_n;
  logic             last_dma;
  logic             last_dma_n;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_n;
  logic             rv_cpu;
  logic             rv_dma;
  logic             hold_cpu;
  logic             dma_rel;
  logic             is_cpu;
  logic             is_dma;

  assign is_cpu = (state == S_CPU);
  assign is_dma = (state == S_DMA);

`ifdef ARB_LOCK_EN
  assign hold_cpu = CPU_LOCK & CPU_REQ;
`else
  assign hold_cpu = 1'b0;
`endif

  assign dma_rel = DMA_LAST | ~DMA_REQ
                 | ((cnt == CNT_MAX) & CPU_REQ);

  // next owner, round-robin tie break and DMA burst cut-off
  always_comb begin
    state_n    = state;
    last_dma_n = last_dma;
    cnt_n      = cnt;
    unique case (1'b1)
      is_cpu: begin
        last_dma_n = 1'b0;
        if (hold_cpu)     state_n = S_CPU;
        else if (DMA_REQ) state_n = S_DMA;
        else              state_n = S_IDLE;
      end
      is_dma: begin
        if (dma_rel) begin
          last_dma_n = 1'b1;
          cnt_n      = '0;
          state_n    = CPU_REQ ? S_CPU : S_IDLE;
        end else if (cnt != CNT_MAX) begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      default: begin
        if (CPU_REQ && (!DMA_REQ || last_dma))
          state_n = S_CPU;
        else if (DMA_REQ)
          state_n = S_DMA;
      end
    endcase
  end

  // state, fairness and read-return registers
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state    <= S_IDLE;
      last_dma <= 1'b1;
      cnt      <= '0;
      rv_cpu   <= 1'b0;
      rv_dma   <= 1'b0;
    end else begin
      state    <= state_n;
      last_dma <= last_dma_n;
      cnt      <= cnt_n;
      rv_cpu   <= is_cpu & ~CPU_WE;
      rv_dma   <= is_dma & ~DMA_WE;
    end
  end

  // RAM strobes and muxes decoded from the current owner
  always_comb begin
    CPU_GNT   = 1'b0;
    DMA_GNT   = 1'b0;
    RAM_CS    = 1'b0;
    RAM_WE    = 1'b0;
    RAM_OE    = 1'b0;
    RAM_ADDR  = '0;
    RAM_WDATA = '0;
    unique case (1'b1)
      is_cpu: begin
        CPU_GNT   = 1'b1;
        RAM_CS    = 1'b1;
        RAM_WE    = CPU_WE;
        RAM_OE    = ~CPU_WE;
        RAM_ADDR  = CPU_ADDR;
        RAM_WDATA = CPU_WDATA;
      end
      is_dma: begin
        DMA_GNT   = 1'b1;
        RAM_CS    = 1'b1;
        RAM_WE    = DMA_WE;
        RAM_OE    = ~DMA_WE;
        RAM_ADDR  = DMA_ADDR;
        RAM_WDATA = DMA_WDATA;
      end
      default: ;
    endcase
  end

  assign CPU_RVALID = rv_cpu;
  assign DMA_RVALID = rv_dma;
  assign RDATA      = (rv_cpu | rv_dma) ? RAM_RDATA : '0;

endmodule
